// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS fetch stage and its bench.
//   - fetch_state_e : fetch FSM states (FETCH = request out, HOLD = instruction held)
//   - ADDR_W_DEF    : default PC / memory address width
//   - PC_INC        : sequential PC increment (one 32-bit word)
//   - OP_J, OP_BEQ  : opcode constants used when building test programs
package mips_pkg;

   localparam int          ADDR_W_DEF = 32;
   localparam logic [31:0] PC_INC     = 32'd4;

   localparam logic [5:0]  OP_J       = 6'b000010;
   localparam logic [5:0]  OP_BEQ     = 6'b000100;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// pc_next: combinational next-PC selection for the fetch stage.
// Ports:
//   pc_plus4  in  ADDR_W  address following the held instruction
//   instr_idx in  26      jump index field (instr[25:0])
//   signimm   in  32      sign-extended immediate of the held instruction
//   PcSrc     in  1       taken branch
//   Jump      in  1       jump (wins over PcSrc)
//   next_pc   out ADDR_W  selected next PC
// ADDR_W is expected to lie in 29..32 so the jump region bits exist.
module pc_next
   import mips_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] pc_plus4,
   input  logic [25:0]       instr_idx,
   input  logic [31:0]       signimm,
   input  logic              PcSrc,
   input  logic              Jump,
   output logic [ADDR_W-1:0] next_pc
);

   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] jmp_target;

   // Word offset to byte offset; truncation gives the mod 2^ADDR_W wrap.
   assign br_off     = ADDR_W'({signimm, 2'b00});
   assign br_target  = pc_plus4 + br_off;
   // Jump stays inside the 256 MB region of the delay-slot address.
   assign jmp_target = {pc_plus4[ADDR_W-1:28], instr_idx, 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (Jump) begin
         next_pc = jmp_target;
      end else if (PcSrc) begin
         next_pc = br_target;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage. Holds the PC, requests words from a
// wait-state-capable instruction memory and keeps each word in an instruction
// register until the downstream retires it.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   imem_req/imem_addr      fetch request (held until imem_ack) and word address (= pc)
//   imem_ack/imem_rdata     memory response and instruction word
//   stall                   downstream cannot retire the held instruction
//   PcSrc, Jump, signimm    branch/jump outcome, sampled on the retire cycle only
//   instr_valid, instr      held instruction and its valid flag
//   opcode, funct           instr[31:26], instr[5:0]
//   pc, pc_plus4            address of held instruction and pc + 4
//   dbg_state               current FSM state (FETCH/HOLD)
//
// Handshake: a fetch is a request/acknowledge pair. imem_req stays high with a
// stable imem_addr from the first FETCH cycle until the cycle in which
// imem_ack is seen; that cycle transfers imem_rdata. Retirement is a
// valid/stall pair: the held instruction retires in the first HOLD cycle with
// stall low, and only that cycle's PcSrc/Jump/signimm are used.
module fetch_unit
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              PcSrc,
   input  logic              Jump,
   input  logic [31:0]       signimm,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic [5:0]        funct,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              dbg_state
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] next_pc;

   assign pc_plus4 = pc_q + ADDR_W'(PC_INC);

   pc_next #(
      .ADDR_W (ADDR_W)
   ) u_pc_next (
      .pc_plus4  (pc_plus4),
      .instr_idx (instr_q[25:0]),
      .signimm   (signimm),
      .PcSrc     (PcSrc),
      .Jump      (Jump),
      .next_pc   (next_pc)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // Acks arriving here are ignored so instr cannot be corrupted.
            if (!stall) begin
               pc_d    = next_pc;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == HOLD);
   assign instr       = instr_q;
   assign opcode      = instr_q[31:26];
   assign funct       = instr_q[5:0];
   assign pc          = pc_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against an
// instruction-level model that predicts the address of every fetch.
module tb_fetch_unit;
   import mips_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        PcSrc;
   logic        Jump;
   logic [31:0] signimm;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        dbg_state;

   always #5 clk = ~clk;

   fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .PcSrc       (PcSrc),
      .Jump        (Jump),
      .signimm     (signimm),
      .instr_valid (instr_valid),
      .instr       (instr),
      .opcode      (opcode),
      .funct       (funct),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .dbg_state   (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];     // predicted fetch addresses, oldest first
   logic [31:0] exp_pc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Architectural next-PC rule, written with plain 32-bit arithmetic.
   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input bit j, input bit b, input logic [31:0] imm);
      logic [31:0] seq;
      seq = cur + 32'd4;
      if (j)      return (seq & 32'hF000_0000) + (word & 32'h03FF_FFFF) * 32'd4;
      else if (b) return seq + imm * 32'd4;
      else        return seq;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic randomize_ignored();
      stall   = 1'($urandom);
      PcSrc   = 1'($urandom);
      Jump    = 1'($urandom);
      signimm = $urandom;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      imem_ack = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check_eq("rst_valid", 32'(instr_valid), 32'd0);
      check_eq("rst_req",   32'(imem_req),    32'd1);
      check_eq("rst_addr",  imem_addr,        32'h0);
      check_eq("rst_instr", instr,            32'h0);
      check_eq("rst_state", 32'(dbg_state),   32'(FETCH));
      exp_q.delete();
      exp_q.push_back(32'h0);
   endtask

   // One instruction: fetch with 'waits' wait cycles, hold with 'stalls'
   // stall cycles, then retire with the given branch/jump outcome.
   task automatic run_instr(input int waits, input int stalls, input bit j, input bit b,
                            input logic [31:0] imm, input logic [31:0] word);
      exp_pc = exp_q.pop_front();
      for (int w = 0; w <= waits; w++) begin
         @(negedge clk);
         check_eq("f_req",   32'(imem_req),    32'd1);
         check_eq("f_addr",  imem_addr,        exp_pc);
         check_eq("f_valid", 32'(instr_valid), 32'd0);
         randomize_ignored();
         imem_ack   = (w == waits);
         imem_rdata = (w == waits) ? word : $urandom;
      end
      for (int s = 0; s <= stalls; s++) begin
         @(negedge clk);
         check_eq("h_valid",  32'(instr_valid), 32'd1);
         check_eq("h_req",    32'(imem_req),    32'd0);
         check_eq("h_state",  32'(dbg_state),   32'(HOLD));
         check_eq("h_instr",  instr,            word);
         check_eq("h_pc",     pc,               exp_pc);
         check_eq("h_pc4",    pc_plus4,         exp_pc + 32'd4);
         check_eq("h_opcode", 32'(opcode),      32'(word[31:26]));
         check_eq("h_funct",  32'(funct),       32'(word[5:0]));
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         if (s < stalls) begin
            randomize_ignored();
            stall = 1'b1;
         end else begin
            stall   = 1'b0;
            Jump    = j;
            PcSrc   = b;
            signimm = imm;
         end
      end
      exp_q.push_back(model_next(exp_pc, word, j, b, imm));
   endtask

   // Retire through a branch whose offset lands exactly on 'target'.
   task automatic goto_pc(input logic [31:0] target);
      logic [31:0] imm;
      imm = 32'($signed(target - exp_q[0] - 32'd4) >>> 2);
      run_instr(0, 0, 1'b0, 1'b1, imm, {OP_BEQ, 26'($urandom)});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
      stall = 1'b0; PcSrc = 1'b0; Jump = 1'b0; signimm = '0;

      // Sequential 0-wait fetch, memory returns addr>>2.
      do_reset();
      for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 1'b0, 32'h0, exp_q[0] >> 2);

      // Wait states at 0x10.
      goto_pc(32'h10);
      run_instr(3, 0, 1'b0, 1'b0, 32'h0, $urandom);

      // Stall at 0x20 for 5 cycles, then sequential to 0x24.
      goto_pc(32'h20);
      run_instr(0, 5, 1'b0, 1'b0, 32'h0, $urandom);
      check_eq("stall_next", exp_q[0], 32'h24);
      run_instr(0, 0, 1'b0, 1'b0, 32'h0, $urandom);

      // Backward branch at 0x40.
      goto_pc(32'h40);
      run_instr(0, 0, 1'b0, 1'b1, 32'hFFFF_FFFE, {OP_BEQ, 26'h0});
      run_instr(0, 0, 1'b0, 1'b0, 32'h0, $urandom);

      // Jump beats branch at 0x1000_0000.
      goto_pc(32'h1000_0000);
      run_instr(1, 1, 1'b1, 1'b1, 32'h0000_0123, {OP_J, 26'h0000100});
      check_eq("jump_target", exp_q[0], 32'h1000_0400);
      run_instr(0, 0, 1'b0, 1'b0, 32'h0, $urandom);

      // PC wrap at the top of the address space.
      goto_pc(32'hFFFF_FFFC);
      run_instr(0, 0, 1'b0, 1'b0, 32'h0, $urandom);
      check_eq("wrap_next", exp_q[0], 32'h0);
      run_instr(0, 0, 1'b0, 1'b0, 32'h0, $urandom);

      // Reset during a FETCH wait.
      goto_pc(32'h80);
      @(negedge clk);
      check_eq("mf_addr", imem_addr, 32'h80);
      imem_ack = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("mf_rst_addr",  imem_addr,        32'h0);
      check_eq("mf_rst_valid", 32'(instr_valid), 32'd0);
      check_eq("mf_rst_instr", instr,            32'h0);
      exp_q.delete();
      exp_q.push_back(32'h0);
      run_instr(0, 0, 1'b0, 1'b0, 32'h0, $urandom);

      // Reset during HOLD.
      goto_pc(32'hC0);
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check_eq("mh_valid", 32'(instr_valid), 32'd1);
      imem_ack = 1'b0;
      stall    = 1'b1;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      stall = 1'b0;
      check_eq("mh_rst_addr",  imem_addr,        32'h0);
      check_eq("mh_rst_valid", 32'(instr_valid), 32'd0);
      check_eq("mh_rst_req",   32'(imem_req),    32'd1);
      exp_q.delete();
      exp_q.push_back(32'h0);

      // Randomized instruction stream.
      for (int i = 0; i < 60; i++) begin
         run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                   32'($signed($urandom_range(0, 127)) - 64), $urandom);
      end
      @(negedge clk);
      check_eq("final_addr", imem_addr, exp_q[0]);

      // ---------------- report ----------------
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the MIPS core. Holds the program counter, requests instruction words from a wait-state-capable instruction memory, and latches each word into an instruction register. The register drives `opcode`/`funct` to the controller and the instruction fields to the datapath. Branch/jump outcomes (`PcSrc`, `Jump`) from the controller are applied when the held instruction retires.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded by reset; bits [1:0] must be 0
- `ADDR_W`, 32, PC / memory address width

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `imem_req`  out  1  fetch request, held until `imem_ack`
- `imem_addr`  out  ADDR_W  word address of request (= PC)
- `imem_ack`  in  1  memory response valid this cycle
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`
- `stall`  in  1  downstream cannot retire the held instruction this cycle
- `PcSrc`  in  1  taken branch for held instruction (from controller)
- `Jump`  in  1  jump for held instruction (from controller)
- `signimm`  in  32  sign-extended immediate of held instruction (from datapath)
- `instr_valid`  out  1  `instr` holds a fetched, unretired instruction
- `instr`  out  32  instruction register
- `opcode`  out  6  `instr[31:26]`
- `funct`  out  6  `instr[5:0]`
- `pc`  out  ADDR_W  address of held instruction
- `pc_plus4`  out  ADDR_W  `pc + 4`

## Operation
- Two-state FSM:
  - **FETCH**: `imem_req`=1, `instr_valid`=0.
  - **HOLD**: `imem_req`=0, `instr_valid`=1.
- FETCH, `imem_ack`=0: stay; `imem_addr` stable.
- FETCH, `imem_ack`=1: `instr` <= `imem_rdata`; go to HOLD.
- HOLD, `stall`=1: stay; `instr` and `pc` frozen.
- HOLD, `stall`=0: retire. `pc` <= next PC; go to FETCH.
- Next PC, by priority:
  - `Jump`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - else `PcSrc`: `pc_plus4 + (signimm << 2)`, mod 2^ADDR_W.
  - else: `pc_plus4`.
- `PcSrc`, `Jump` and `signimm` are sampled only on the retire cycle. They are ignored in FETCH and while stalled.
- `pc_plus4` wraps mod 2^ADDR_W; 32'hFFFF_FFFC + 4 = 0.
- `imem_ack` in HOLD is ignored; it must not corrupt `instr`.
- `pc[1:0]` is always 00. Shifted branch offsets and jump targets guarantee this.
- `opcode`, `funct` and `pc_plus4` are combinational from the registers; `instr` is zero in FETCH only after reset.

## Timing
- Reset (one edge with `reset`=1) sets:
  - `pc`=RESET_PC, state=FETCH, `instr`=0, `instr_valid`=0.
  - Hence `imem_req`=1 and `imem_addr`=RESET_PC in the first cycle after reset.
- Fetch latency: an ack in cycle N puts `instr_valid`=1 and the new `instr` in cycle N+1.
- With 0-wait memory (ack in the first FETCH cycle) and no stall, one instruction retires every 2 cycles.
- Each memory wait cycle adds 1 cycle; each stall cycle adds 1 cycle.
- Retire in cycle N: the new `imem_addr` appears in cycle N+1.
- Reset has priority over everything, including mid-FETCH with an outstanding request and mid-HOLD. The in-flight request is abandoned.
- The memory must also reset synchronously on `reset`, so no stale ack arrives after reset.
- `Jump`=1 and `PcSrc`=1 in the same retire cycle: the jump wins.

## Structure
- Shared package `mips_pkg` holds:
  - the FSM state enum (`FETCH`, `HOLD`);
  - the `ADDR_W` default;
  - the PC increment constant (4);
  - opcode constants used by tests (`OP_J`=6'b000010, `OP_BEQ`=6'b000100).
- One natural sub-module, `pc_next`: purely combinational next-PC mux and adders. Inputs are `pc_plus4`, `instr[25:0]`, `signimm`, `PcSrc` and `Jump`.
- The FSM, PC register and instruction register live in `fetch_unit`.

## Test plan
- **Reset/sequential:** reset with RESET_PC=0, 0-wait memory returning `addr>>2`, no stall.
  - Required: `imem_addr` sequence 0, 4, 8, with a request every 2 cycles.
  - Required: `instr_valid` pulses carry `instr`=0, 1, 2.
- **Wait states:** memory acks 3 cycles after req at address 0x10.
  - Required: `imem_addr` holds 0x10 for 4 cycles.
  - Required: `instr` updates one cycle after ack; no spurious `instr_valid`.
- **Stall:** hold `stall`=1 for 5 cycles with the instruction at pc=0x20.
  - Required: `instr`, `pc`=0x20 and `instr_valid`=1 stable throughout.
  - Required: after release, the next `imem_addr`=0x24.
- **Branch:** at pc=0x40 retire with `PcSrc`=1 and `signimm`=32'hFFFF_FFFE.
  - Required: next `imem_addr`=0x3C.
- **Jump vs branch:** pc=0x1000_0000, `instr[25:0]`=26'h0000100, `Jump`=1 and `PcSrc`=1 together.
  - Required: next `imem_addr`=0x1000_0400.
- **Reset mid-operation and wrap:**
  - Assert reset during a FETCH wait. Required: `imem_addr`=RESET_PC next cycle and `instr_valid`=0.
  - Retire at pc=0xFFFF_FFFC. Required: next `imem_addr`=0.
